// File: rtl/key_sweep_controller.sv
// Sweeps a locked multiplier netlist through a table of candidate keys, replaying a shared
// operand set per key and reporting mismatch count and output Hamming distance for each key.
//
// state    | meaning
// IDLE     | waiting for start_i
// LOAD_KEY | register table[key_idx], clear counters, address vector 0
// FETCH    | ROM data valid; register operands and golden product
// SETTLE   | wait DUT_LAT cycles for the netlist to settle
// CHECK    | compare result_i with golden, advance to next vector
// REPORT   | hold per-key result until consumer handshake
module key_sweep_controller #(
    parameter int OP_W     = 8,
    parameter int KEY_W    = 32,
    parameter int NUM_KEYS = 16,
    parameter int NUM_VEC  = 10000,
    parameter int DUT_LAT  = 1,
    parameter int CNT_W    = 16,
    parameter int HD_W     = 20,
    localparam int KI_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    localparam int VA_W    = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [KI_W:0]       num_keys_i,
    input  logic                key_wr_en_i,
    input  logic [KI_W-1:0]     key_wr_idx_i,
    input  logic [KEY_W-1:0]    key_wr_data_i,
    output logic [VA_W-1:0]     vec_addr_o,
    input  logic [2*OP_W-1:0]   vec_data_i,
    output logic [OP_W-1:0]     operand1_o,
    output logic [OP_W-1:0]     operand2_o,
    output logic [KEY_W-1:0]    keyinput_o,
    input  logic [2*OP_W-1:0]   result_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [KI_W-1:0]     res_key_idx_o,
    output logic [CNT_W-1:0]    res_err_cnt_o,
    output logic [HD_W-1:0]     res_hd_sum_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int RES_W = 2 * OP_W;
    localparam int PC_W  = $clog2(RES_W + 1);
    localparam int SC_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        FETCH,
        SETTLE,
        CHECK,
        REPORT
    } state_t;

    state_t             state_q, state_d;
    logic [KI_W-1:0]    key_idx_q, key_idx_d;
    logic [KI_W:0]      num_keys_q, num_keys_d;
    logic [VA_W-1:0]    vec_idx_q, vec_idx_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [OP_W-1:0]    op1_q, op1_d;
    logic [OP_W-1:0]    op2_q, op2_d;
    logic [RES_W-1:0]   golden_q, golden_d;
    logic [SC_W-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [HD_W-1:0]    hd_q, hd_d;
    logic               done_q, done_d;

    logic [KEY_W-1:0]   key_tab [NUM_KEYS];
    logic [KI_W:0]      num_keys_clamped;
    logic [PC_W-1:0]    diff_bits;
    logic [HD_W:0]      hd_sum;

    function automatic logic [PC_W-1:0] popcnt(input logic [RES_W-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < RES_W; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // Table is deliberately not reset; a write only reaches keyinput_o at the next LOAD_KEY.
    always_ff @(posedge clk_i) begin
        if (key_wr_en_i && (32'(key_wr_idx_i) < NUM_KEYS)) begin
            key_tab[key_wr_idx_i] <= key_wr_data_i;
        end
    end

    always_comb begin
        num_keys_clamped = num_keys_i;
        if (num_keys_i == '0) begin
            num_keys_clamped = (KI_W+1)'(1);
        end else if (num_keys_i > (KI_W+1)'(NUM_KEYS)) begin
            num_keys_clamped = (KI_W+1)'(NUM_KEYS);
        end
    end

    assign diff_bits = popcnt(result_i ^ golden_q);
    assign hd_sum    = {1'b0, hd_q} + (HD_W+1)'(diff_bits);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            key_idx_q  <= '0;
            num_keys_q <= '0;
            vec_idx_q  <= '0;
            key_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            golden_q   <= '0;
            settle_q   <= '0;
            err_q      <= '0;
            hd_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_idx_q  <= key_idx_d;
            num_keys_q <= num_keys_d;
            vec_idx_q  <= vec_idx_d;
            key_q      <= key_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            golden_q   <= golden_d;
            settle_q   <= settle_d;
            err_q      <= err_d;
            hd_q       <= hd_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_idx_d  = key_idx_q;
        num_keys_d = num_keys_q;
        vec_idx_d  = vec_idx_q;
        key_d      = key_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        golden_d   = golden_q;
        settle_d   = settle_q;
        err_d      = err_q;
        hd_d       = hd_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // done_q marks the cycle right after the last handshake; start is dropped there.
                if (start_i && !done_q) begin
                    key_idx_d  = '0;
                    num_keys_d = num_keys_clamped;
                    state_d    = LOAD_KEY;
                end
            end
            LOAD_KEY: begin
                key_d     = key_tab[key_idx_q];
                err_d     = '0;
                hd_d      = '0;
                vec_idx_d = '0;
                state_d   = FETCH;
            end
            FETCH: begin
                op1_d    = vec_data_i[RES_W-1:OP_W];
                op2_d    = vec_data_i[OP_W-1:0];
                golden_d = RES_W'(vec_data_i[RES_W-1:OP_W]) * RES_W'(vec_data_i[OP_W-1:0]);
                settle_d = SC_W'(DUT_LAT);
                state_d  = SETTLE;
            end
            SETTLE: begin
                settle_d = settle_q - SC_W'(1);
                if (settle_q <= SC_W'(1)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if ((result_i != golden_q) && (err_q != '1)) begin
                    err_d = err_q + CNT_W'(1);
                end
                hd_d = hd_sum[HD_W] ? '1 : hd_sum[HD_W-1:0];
                if (vec_idx_q == VA_W'(NUM_VEC - 1)) begin
                    state_d = REPORT;
                end else begin
                    vec_idx_d = vec_idx_q + VA_W'(1);
                    state_d   = FETCH;
                end
            end
            REPORT: begin
                if (res_ready_i) begin
                    if ({1'b0, key_idx_q} == num_keys_q - (KI_W+1)'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        key_idx_d = key_idx_q + KI_W'(1);
                        state_d   = LOAD_KEY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address leads the state register by one cycle so the synchronous ROM has data in FETCH.
    assign vec_addr_o    = vec_idx_d;
    assign operand1_o    = op1_q;
    assign operand2_o    = op2_q;
    assign keyinput_o    = key_q;
    assign res_valid_o   = (state_q == REPORT);
    assign res_key_idx_o = key_idx_q;
    assign res_err_cnt_o = err_q;
    assign res_hd_sum_o  = hd_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;

endmodule

// File: tb/tb_key_sweep_controller.sv
// Directed bench for key_sweep_controller: a 4-vector sweep instance and a 5-vector,
// 2-bit-counter instance, each with its own ROM model and key-dependent netlist stub.
module tb_key_sweep_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // shared key-table write bus
    logic        wr_en = 1'b0;
    logic [3:0]  wr_idx = '0;
    logic [31:0] wr_data = '0;

    // main instance: NUM_VEC=4
    logic        start = 1'b0, ready = 1'b0;
    logic [4:0]  num_keys = 5'd1;
    logic [1:0]  vec_addr;
    logic [15:0] vec_data = '0;
    logic [7:0]  op1, op2;
    logic [31:0] keyin;
    logic [15:0] result;
    logic        valid, busy, done;
    logic [3:0]  key_idx;
    logic [15:0] err;
    logic [19:0] hd;

    // saturation instance: NUM_VEC=5, CNT_W=2
    logic        s_start = 1'b0, s_ready = 1'b0;
    logic [4:0]  s_num_keys = 5'd0;
    logic [2:0]  s_vec_addr;
    logic [15:0] s_vec_data = '0;
    logic [7:0]  s_op1, s_op2;
    logic [31:0] s_keyin;
    logic [15:0] s_result;
    logic        s_valid, s_busy, s_done;
    logic [3:0]  s_key_idx;
    logic [1:0]  s_err;
    logic [19:0] s_hd;

    logic [15:0] rom   [4] = '{16'h0305, 16'hFFFF, 16'h007A, 16'h1234};
    logic [15:0] s_rom [5] = '{16'h0101, 16'h0203, 16'h1010, 16'hFF01, 16'hABCD};

    always @(posedge clk) vec_data <= rom[vec_addr];
    always @(posedge clk) s_vec_data <= (s_vec_addr < 3'd5) ? s_rom[s_vec_addr] : 16'h0;

    function automatic logic [15:0] stub(input logic [7:0] a, input logic [7:0] b,
                                         input logic [31:0] k);
        logic [15:0] p;
        p = {8'h0, a} * {8'h0, b};
        if (k == 32'hF6301537) return p;
        if (k == 32'hC0301537) return p ^ 16'hFFFF;
        return p ^ 16'h0001;
    endfunction

    assign result   = stub(op1, op2, keyin);
    assign s_result = stub(s_op1, s_op2, s_keyin);

    key_sweep_controller #(.NUM_VEC(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .num_keys_i(num_keys),
        .key_wr_en_i(wr_en), .key_wr_idx_i(wr_idx), .key_wr_data_i(wr_data),
        .vec_addr_o(vec_addr), .vec_data_i(vec_data),
        .operand1_o(op1), .operand2_o(op2), .keyinput_o(keyin), .result_i(result),
        .res_valid_o(valid), .res_ready_i(ready), .res_key_idx_o(key_idx),
        .res_err_cnt_o(err), .res_hd_sum_o(hd), .busy_o(busy), .done_o(done)
    );

    key_sweep_controller #(.NUM_VEC(5), .CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .num_keys_i(s_num_keys),
        .key_wr_en_i(wr_en), .key_wr_idx_i(wr_idx), .key_wr_data_i(wr_data),
        .vec_addr_o(s_vec_addr), .vec_data_i(s_vec_data),
        .operand1_o(s_op1), .operand2_o(s_op2), .keyinput_o(s_keyin), .result_i(s_result),
        .res_valid_o(s_valid), .res_ready_i(s_ready), .res_key_idx_o(s_key_idx),
        .res_err_cnt_o(s_err), .res_hd_sum_o(s_hd), .busy_o(s_busy), .done_o(s_done)
    );

    // operand-change timestamps for the sample-spacing check
    bit   cap = 1'b0;
    int   chg_q[$];
    logic [15:0] prev_ops = '0;
    always @(posedge clk) begin
        #2;
        if ({op1, op2} != prev_ops && cap) chg_q.push_back(cyc);
        prev_ops = {op1, op2};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_key(input logic [3:0] idx, input logic [31:0] data);
        wr_en = 1'b1; wr_idx = idx; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_valid(input bit sat, input string tag);
        int n = 0;
        while (!(sat ? s_valid : valid) && n < 300) begin
            tick();
            n++;
        end
        chk(tag, {31'h0, (sat ? s_valid : valid)}, 32'h1);
    endtask

    task automatic handshake();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    logic [89:0] snap;
    bit          moved;
    int          c0;

    initial begin
        tick(3);
        rst = 1'b0;
        tick();
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_outs", {31'h0, |{valid, done, key_idx, err, hd, vec_addr, op1, op2, keyin}}, 0);

        // single ideal key, sample spacing, done pulse, start-during-done ignored
        write_key(4'd0, 32'hF6301537);
        num_keys = 5'd1;
        cap = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(1'b0, "t1_valid");
        cap = 1'b0;
        chk("t1_key", {28'h0, key_idx}, 0);
        chk("t1_err", {16'h0, err}, 0);
        chk("t1_hd", {12'h0, hd}, 0);
        chk("t1_nchg", chg_q.size(), 4);
        for (int i = 1; i < chg_q.size(); i++) chk("t1_spacing", chg_q[i] - chg_q[i-1], 3);
        handshake();
        chk("t1_done", {31'h0, done}, 1);
        chk("t1_valid_low", {31'h0, valid}, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_done_once", {31'h0, done}, 0);
        chk("t1_start_in_done", {31'h0, busy}, 0);

        // two keys with stall at first REPORT
        write_key(4'd1, 32'hF6301527);
        num_keys = 5'd2;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(1'b0, "t2_valid0");
        snap = {key_idx, err, hd, vec_addr, op1, op2, keyin};
        moved = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ({key_idx, err, hd, vec_addr, op1, op2, keyin} != snap || !valid) moved = 1'b1;
        end
        chk("t2_stall_stable", {31'h0, moved}, 0);
        chk("t2_key0", {28'h0, key_idx}, 0);
        chk("t2_err0", {16'h0, err}, 0);
        chk("t2_hd0", {12'h0, hd}, 0);
        handshake();
        chk("t2_valid_drop", {31'h0, valid}, 0);
        chk("t2_no_done", {31'h0, done}, 0);
        wait_valid(1'b0, "t2_valid1");
        chk("t2_key1", {28'h0, key_idx}, 1);
        chk("t2_err1", {16'h0, err}, 4);
        chk("t2_hd1", {12'h0, hd}, 4);
        handshake();
        chk("t2_done", {31'h0, done}, 1);

        // all-bits-flipped key
        write_key(4'd0, 32'hC0301537);
        num_keys = 5'd1;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(1'b0, "t3_valid");
        chk("t3_err", {16'h0, err}, 4);
        chk("t3_hd", {12'h0, hd}, 64);
        chk("t3_ops_hold", {16'h0, op1, op2}, 32'h1234);
        chk("t3_key", keyin, 32'hC0301537);
        handshake();

        // reset during SETTLE of key 1
        write_key(4'd0, 32'hF6301537);
        num_keys = 5'd2;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(1'b0, "t4_valid0");
        handshake();
        tick(2);
        chk("t4_on_key1", keyin, 32'hF6301527);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_busy", {31'h0, busy}, 0);
        chk("t4_rst_outs", {31'h0, |{valid, done, key_idx, err, hd, vec_addr, op1, op2, keyin}}, 0);
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(1'b0, "t4_valid_re");
        chk("t4_key_re", {28'h0, key_idx}, 0);
        chk("t4_err_re", {16'h0, err}, 0);
        chk("t4_hd_re", {12'h0, hd}, 0);
        handshake();

        // saturating 2-bit counter, num_keys=0, start mid-sweep ignored
        write_key(4'd0, 32'hF6301527);
        s_num_keys = 5'd0;
        s_start = 1'b1; tick(); s_start = 1'b0;
        c0 = cyc;
        tick(5);
        s_start = 1'b1; tick(); s_start = 1'b0;
        wait_valid(1'b1, "t5_valid");
        chk("t5_latency", cyc - c0, 16);
        chk("t5_key", {28'h0, s_key_idx}, 0);
        chk("t5_err_sat", {30'h0, s_err}, 3);
        chk("t5_hd", {12'h0, s_hd}, 5);
        s_ready = 1'b1; tick(); s_ready = 1'b0;
        chk("t5_done", {31'h0, s_done}, 1);
        tick();
        chk("t5_idle", {31'h0, s_busy}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_sweep_controller.md
Name: key_sweep_controller

Overview:
- Sequences a locked 8x8 multiplier netlist (operands plus 32-bit key) through a programmed table of candidate keys, replaying one shared operand-vector set per key.
- For each key: computes the golden product internally, compares it with the netlist output, and reports the mismatch count and the accumulated output Hamming distance.
- Sits between a vector ROM (synchronous, 1-cycle read), the locked netlist (instantiated alongside, combinational), and a result consumer.

Parameters:
- OP_W, 8, operand width; result width is 2*OP_W.
- KEY_W, 32, key width.
- NUM_KEYS, 16, key table depth; index width KI_W = clog2(NUM_KEYS).
- NUM_VEC, 10000, operand pairs per key; address width VA_W = clog2(NUM_VEC).
- DUT_LAT, 1, settle cycles (1..15) after operands/key change before result_i is sampled.
- CNT_W, 16, mismatch counter width (saturating).
- HD_W, 20, Hamming-sum width (saturating).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  pulse; begin sweep from key 0
- num_keys_i  in  KI_W+1  keys to sweep, 1..NUM_KEYS; sampled at start; 0 treated as 1
- key_wr_en_i  in  1  key table write strobe
- key_wr_idx_i  in  KI_W  table index
- key_wr_data_i  in  KEY_W  key value
- vec_addr_o  out  VA_W  ROM address
- vec_data_i  in  2*OP_W  {operand1, operand2}; valid 1 cycle after address
- operand1_o  out  OP_W  to netlist
- operand2_o  out  OP_W  to netlist
- keyinput_o  out  KEY_W  to netlist
- result_i  in  2*OP_W  netlist product
- res_valid_o  out  1  per-key result valid
- res_ready_i  in  1  consumer accepts
- res_key_idx_o  out  KI_W  key index reported
- res_err_cnt_o  out  CNT_W  vectors with result_i != golden
- res_hd_sum_o  out  HD_W  sum of popcount(result_i ^ golden)
- busy_o  out  1  sweep in progress
- done_o  out  1  one-cycle pulse after the final result handshake

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0. Key table contents are not reset.
- Key table: written whenever key_wr_en_i=1 in any state. A write to the index currently being swept takes effect at that index's next LOAD_KEY only; keyinput_o holds its registered copy.
- FSM states: IDLE, LOAD_KEY, FETCH, SETTLE, CHECK, REPORT.
- IDLE: busy_o=0. start_i -> LOAD_KEY; key_idx=0; latch num_keys.
- LOAD_KEY: keyinput_o <= table[key_idx]; clear err/hd; vec_idx=0; vec_addr_o <= 0 -> FETCH.
- FETCH (1 cycle, ROM returns data):
  - operand1_o <= vec_data_i[2*OP_W-1:OP_W]; operand2_o <= vec_data_i[OP_W-1:0].
  - golden <= unsigned product of the two fields.
  - Settle counter <= DUT_LAT -> SETTLE.
- SETTLE: decrement each cycle; at 1 -> CHECK. The netlist is therefore sampled exactly DUT_LAT cycles after its operands change.
- CHECK (1 cycle):
  - If result_i != golden: err += 1.
  - hd += popcount(result_i ^ golden).
  - Both counters saturate at all-ones.
  - If vec_idx == NUM_VEC-1 -> REPORT; else vec_idx+1, vec_addr_o <= vec_idx+1, -> FETCH.
- Per-vector cost: 2+DUT_LAT cycles. Per-key cost: 1 + NUM_VEC*(2+DUT_LAT) cycles before REPORT.
- REPORT:
  - res_valid_o=1; res_* fields stable until res_valid_o && res_ready_i.
  - On handshake: res_valid_o=0 the next cycle.
  - If key_idx == num_keys-1 -> IDLE with done_o pulsed 1 cycle; else key_idx+1 -> LOAD_KEY.
  - Unbounded res_ready_i stall is legal.
- busy_o=1 in every state except IDLE.
- start_i while busy is ignored. start_i in the same cycle that done_o pulses is also ignored.
- Operands and key hold their last values in IDLE and REPORT.
- Reset mid-sweep aborts immediately. No partial result is emitted; the next start_i restarts from key 0.

Test Plan:
- Table[0]=F6301537, ideal stub (result_i = op1*op2), NUM_VEC=4 with vectors (03,05),(FF,FF),(00,7A),(12,34), num_keys=1 -> result key 0, err=0, hd=0; done_o pulses; per-vector sample spacing 3 cycles (DUT_LAT=1).
- Stub XORs result with 0x0001 when key != F6301537; keys {F6301537, F6301527}, num_keys=2 -> key 0: err=0, hd=0; key 1: err=4, hd=4; results in index order.
- Stub XORs result with 0xFFFF for key C0301537, vector (FF,FF) -> golden FE01; err=4, hd=64.
- Hold res_ready_i=0 for 50 cycles at the first REPORT -> res_* stable, vec_addr_o and operands frozen, no second result until the handshake.
- Assert rst_i during SETTLE of key 1 -> all outputs 0 asynchronously; a following start_i yields key 0 again with fresh counts.
- Force CNT_W=2 with 5 mismatching vectors -> err saturates at 3; start_i pulsed mid-sweep has no effect.
